// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/seq_divider_cla_subtractor.sv
// diff = a - b computed as a + ~b + 1 on 4-bit carry-lookahead groups; borrow = ~carry_out.
module cla_subtractor #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int NG = (WIDTH + 3) / 4;
  localparam int PW = NG * 4;

  logic [PW-1:0] a_ext, nb_ext;
  logic [PW-1:0] p, g, c;
  logic [NG-1:0] gp, gg;
  logic [NG:0]   gc;
  logic          unused_carry;

  // Pad bits see a=0, ~b=1: they propagate the carry unchanged to the top.
  assign a_ext  = PW'(a);
  assign nb_ext = ~(PW'(b));
  assign p      = a_ext ^ nb_ext;
  assign g      = a_ext & nb_ext;

  always_comb begin
    gp = '0;
    gg = '0;
    gc = '0;
    c  = '0;
    gc[0] = 1'b1;
    for (int k = 0; k < NG; k++) begin
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  always_comb begin
    diff = '0;
    for (int i = 0; i < WIDTH; i++) diff[i] = p[i] ^ c[i];
  end

  assign borrow       = ~gc[NG];
  assign unused_carry = ^c;

endmodule

// File: rtl/seq_divider.sv
// Restoring divider: one trial subtraction per cycle, signs applied in a final fix-up step.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q, rem, dvsr_mag, dvnd_raw;
  logic             q_neg, r_neg, dvsr_zero;

  logic [WIDTH:0]   rem_sh, trial;
  logic             trial_borrow;
  logic [WIDTH-1:0] dvnd_neg, dvsr_neg, q_neg_val, rem_neg_val;
  logic             nb0, nb1, nb2, nb3;
  logic             unused_bits;

  assign rem_sh = {rem, q[WIDTH-1]};

  cla_subtractor #(.WIDTH(WIDTH+1)) u_trial (
    .a(rem_sh), .b({1'b0, dvsr_mag}), .diff(trial), .borrow(trial_borrow)
  );
  cla_subtractor #(.WIDTH(WIDTH)) u_neg_dvnd (
    .a('0), .b(dividend), .diff(dvnd_neg), .borrow(nb0)
  );
  cla_subtractor #(.WIDTH(WIDTH)) u_neg_dvsr (
    .a('0), .b(divisor), .diff(dvsr_neg), .borrow(nb1)
  );
  cla_subtractor #(.WIDTH(WIDTH)) u_neg_q (
    .a('0), .b(q), .diff(q_neg_val), .borrow(nb2)
  );
  cla_subtractor #(.WIDTH(WIDTH)) u_neg_rem (
    .a('0), .b(rem), .diff(rem_neg_val), .borrow(nb3)
  );

  assign unused_bits = ^{nb0, nb1, nb2, nb3, trial[WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = DIV;
      DIV: begin
        busy = 1'b1;
        if (count == CNT_W'(1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      q           <= '0;
      rem         <= '0;
      dvsr_mag    <= '0;
      dvnd_raw    <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dvsr_zero   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        // capture: magnitudes and result signs
        IDLE: if (start) begin
          q         <= (is_signed && dividend[WIDTH-1]) ? dvnd_neg : dividend;
          dvsr_mag  <= (is_signed && divisor[WIDTH-1]) ? dvsr_neg : divisor;
          rem       <= '0;
          dvnd_raw  <= dividend;
          q_neg     <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg     <= is_signed & dividend[WIDTH-1];
          dvsr_zero <= (divisor == '0);
          count     <= CNT_W'(WIDTH);
        end
        // iterate: shift in one dividend bit, keep the trial difference if it did not borrow
        DIV: begin
          if (!trial_borrow) begin
            rem <= trial[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b0};
          end
          count <= count - CNT_W'(1);
        end
        // fix-up: restore signs, or report divide-by-zero with the raw dividend
        FIX: begin
          if (dvsr_zero) begin
            quotient    <= '1;
            remainder   <= dvnd_raw;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_neg ? q_neg_val : q;
            remainder   <= r_neg ? rem_neg_val : rem;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring integer divider for the miniRISC execute stage. It is the inverse-direction companion to the lookahead adder datapath: each step is one trial subtraction built on carry-lookahead logic.
- Accepts one divide request via a start/busy/done handshake and produces quotient and remainder after a fixed latency.
- Supports signed (two's complement, truncating toward zero) and unsigned operands.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- is_signed  input  1  1 = signed divide, 0 = unsigned; captured with start.
- dividend  input  WIDTH  numerator; captured with start.
- divisor  input  WIDTH  denominator; captured with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; quotient/remainder valid.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  flag for the last operation, held like the results.

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; busy, done and div_by_zero=0; quotient and remainder=0; all internal registers cleared. Reset mid-operation aborts the operation, and no done is produced.
- States:
  - IDLE: start=1 captures operands, the sign flags (sign of the quotient = sdividend^sdivisor, sign of the remainder = sdividend; both only when is_signed=1) and the magnitudes (two's-complement negate if signed and MSB=1). Sets counter=WIDTH and goes to DIV.
  - DIV: each cycle, rem_sh = {rem[WIDTH-1:0], q[WIDTH-1]} is (WIDTH+1) bits. diff = rem_sh - {0, |divisor|} via the cla subtractor.
    - If there is no borrow (diff >= 0): rem <= diff, q <= {q[WIDTH-2:0], 1}.
    - Else: rem <= rem_sh, q <= {q[WIDTH-2:0], 0}.
    - counter decrements each cycle; when counter reaches 1, go to FIX.
  - FIX: apply the signs (negate q if the quotient sign is set, negate rem if the remainder sign is set) and write the outputs.
    - If divisor==0: quotient = all ones, remainder = the original dividend (unmodified bits), div_by_zero=1.
    - Go to DONE.
  - DONE: done=1 for exactly this cycle, busy=0, then IDLE. A start in the DONE cycle is ignored.
- Latency: start accepted at cycle T. busy=1 on cycles T+1..T+WIDTH+1. done=1 at cycle T+WIDTH+2 (34 for WIDTH=32). The latency is fixed, including for divide-by-zero.
- start while busy=1: ignored, with no effect on the in-flight operation.
- Signed overflow (-2^(WIDTH-1) / -1): quotient = -2^(WIDTH-1), remainder = 0. This falls out naturally from unsigned magnitude arithmetic; there is no trap.
- Remainder sign always follows the dividend, and |remainder| < |divisor|.
- The outputs only change in FIX or on reset.

Decomposition:
- Shared package (div_pkg):
  - State encoding: IDLE=2'd0, DIV=2'd1, FIX=2'd2, DONE=2'd3.
  - DIV_WIDTH default of 32.
  - Counter width $clog2(WIDTH)+1.
- Sub-module cla_subtractor (WIDTH+1 bits): A + ~B + 1. It uses 4-bit P/G groups feeding the existing lookahead carry unit hierarchically, and outputs diff and borrow (= ~carry_out).
- The two's-complement negations in capture and FIX reuse cla_subtractor instances (0 - x).

Test Plan:
- Unsigned 100/7, start at cycle 0 -> done at cycle 34 only; quotient=14, remainder=2, div_by_zero=0; busy high cycles 1-33.
- Signed -7/2 (0xFFFFFFF9 / 0x2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7/-2 -> quotient=-3, remainder=1.
- Divide by zero: unsigned 5/0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done at cycle 34. A next op of 9/3 clears the flag.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. The same operands unsigned -> quotient=0, remainder=0x80000000.
- Handshake: start pulsed again at cycle 10 with different operands during 100/7 -> ignored, result 14/2 at cycle 34. Back-to-back start at cycle 35 is accepted, and its done comes at cycle 69.
- Reset at cycle 15 mid-operation -> busy=0, outputs=0 from cycle 16, no done pulse. A new start at cycle 17 completes normally at cycle 51.
